conv33_window: RTL and testbench

Sliding-window generator feeding the 3x3 convolution compute stage. Accepts a raster-order pixel stream (one pixel per `pix_valid` cycle, row-major, top-left first) and buffers the two previous image rows in internal line buffers. For every input position where a full 3x3 neighbourhood exists, it presents the window on nine registered outputs with a one-cycle `conv33_en` strobe. Convolution is stride 1 with no padding, so each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

---
 rtl/conv33_window.sv | 130 +++++++++++++
 tb/tb_conv33_window.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv33_window.sv
// 3x3 sliding-window generator: two line buffers feed a column-shift window,
// and each full neighbourhood is registered onto data_* with a conv33_en strobe.
module conv33_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_sync,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] data_0_0,
  output logic [DATA_WIDTH-1:0] data_0_1,
  output logic [DATA_WIDTH-1:0] data_0_2,
  output logic [DATA_WIDTH-1:0] data_1_0,
  output logic [DATA_WIDTH-1:0] data_1_1,
  output logic [DATA_WIDTH-1:0] data_1_2,
  output logic [DATA_WIDTH-1:0] data_2_0,
  output logic [DATA_WIDTH-1:0] data_2_1,
  output logic [DATA_WIDTH-1:0] data_2_2,
  output logic                  conv33_en,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_en;
  logic          r_done;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_emit;
  logic          w_last;

  // frame_sync re-labels the current pixel as (0,0) before anything uses the position
  assign w_col  = frame_sync ? '0 : r_col;
  assign w_row  = frame_sync ? '0 : r_row;
  assign w_emit = pix_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_en   <= w_emit;
      r_done <= w_emit && w_last;
      if (pix_valid) begin
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end else if (frame_sync) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  // Column-addressed line buffers: entry [col] holds the same column one/two rows up
  logic [DATA_WIDTH-1:0] r_lb_a [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb_b [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] w_new_col [3];

  assign w_new_col[0] = r_lb_b[w_col];
  assign w_new_col[1] = r_lb_a[w_col];
  assign w_new_col[2] = pix_in;

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb_a[w_col] <= pix_in;
      r_lb_b[w_col] <= r_lb_a[w_col];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] r_win_c0;
      logic [DATA_WIDTH-1:0] r_win_c1;
      logic [DATA_WIDTH-1:0] r_d0;
      logic [DATA_WIDTH-1:0] r_d1;
      logic [DATA_WIDTH-1:0] r_d2;

      // Only the two older columns are stored; the newest column comes straight in
      always_ff @(posedge clk) begin
        if (pix_valid) begin
          r_win_c0 <= r_win_c1;
          r_win_c1 <= w_new_col[gi];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d0 <= '0;
          r_d1 <= '0;
          r_d2 <= '0;
        end else if (w_emit) begin
          r_d0 <= r_win_c0;
          r_d1 <= r_win_c1;
          r_d2 <= w_new_col[gi];
        end
      end
    end
  endgenerate

  assign data_0_0   = g_row[0].r_d0;
  assign data_0_1   = g_row[0].r_d1;
  assign data_0_2   = g_row[0].r_d2;
  assign data_1_0   = g_row[1].r_d0;
  assign data_1_1   = g_row[1].r_d1;
  assign data_1_2   = g_row[1].r_d2;
  assign data_2_0   = g_row[2].r_d0;
  assign data_2_1   = g_row[2].r_d1;
  assign data_2_2   = g_row[2].r_d2;
  assign conv33_en  = r_en;
  assign frame_done = r_done;

endmodule

// File: tb/tb_conv33_window.sv
// Directed bench for conv33_window on a 5x4 image; a tiny frame model supplies
// the expected window, strobe and frame_done after every clock.
module tb_conv33_window;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk;
  logic          rst_n;
  logic          frame_sync;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic [DW-1:0] data_0_0, data_0_1, data_0_2;
  logic [DW-1:0] data_1_0, data_1_1, data_1_2;
  logic [DW-1:0] data_2_0, data_2_1, data_2_2;
  logic          conv33_en;
  logic          frame_done;

  conv33_window #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .pix_in(pix_in), .pix_valid(pix_valid),
    .data_0_0(data_0_0), .data_0_1(data_0_1), .data_0_2(data_0_2),
    .data_1_0(data_1_0), .data_1_1(data_1_1), .data_1_2(data_1_2),
    .data_2_0(data_2_0), .data_2_1(data_2_1), .data_2_2(data_2_2),
    .conv33_en(conv33_en), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_pulse = 0;

  logic [DW-1:0] img [H][W];
  logic [DW-1:0] frm [W*H];
  int            m_row, m_col;
  logic [71:0]   exp_win;
  logic          exp_en, exp_fd;

  function automatic logic [71:0] dut_win();
    return {data_0_0, data_0_1, data_0_2, data_1_0, data_1_1, data_1_2,
            data_2_0, data_2_1, data_2_2};
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // one clock: drive inputs, advance the model, compare everything after the edge
  task automatic step(input logic v, input logic [DW-1:0] val, input logic fs);
    pix_valid  = v;
    pix_in     = val;
    frame_sync = fs;
    @(posedge clk);
    #1;
    pix_valid  = 1'b0;
    frame_sync = 1'b0;
    if (fs) begin
      m_row = 0;
      m_col = 0;
    end
    exp_en = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      img[m_row][m_col] = val;
      if (m_row >= 2 && m_col >= 2) begin
        exp_en  = 1'b1;
        exp_fd  = (m_row == H - 1) && (m_col == W - 1);
        exp_win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win = {exp_win[63:0], img[m_row - 2 + r][m_col - 2 + c]};
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    if (conv33_en) begin
      n_pulse++;
      $display("win fd=%0b data=%h", frame_done, dut_win());
    end
    check("en", {71'd0, conv33_en}, {71'd0, exp_en});
    check("fd", {71'd0, frame_done}, {71'd0, exp_fd});
    check("win", dut_win(), exp_win);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_win", dut_win(), 72'd0);
    check("rst_en", {71'd0, conv33_en}, 72'd0);
    check("rst_fd", {71'd0, frame_done}, 72'd0);
    m_row   = 0;
    m_col   = 0;
    exp_win = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // gap_mode: 0 continuous, 1 alternate idle cycles, 2 random 0..2 idle cycles
  task automatic send_frame(input int first, input int last, input int gap_mode);
    for (int k = first; k <= last; k++) begin
      step(1'b1, frm[k], 1'b0);
      if (gap_mode == 1) step(1'b0, 8'h00, 1'b0);
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_sync = 1'b0; pix_in = '0; pix_valid = 1'b0;
    m_row = 0; m_col = 0; exp_win = '0; exp_en = 1'b0; exp_fd = 1'b0;
    for (int k = 0; k < W * H; k++) frm[k] = 8'(k);
    do_reset();
    step(1'b0, 8'h00, 1'b0);

    // continuous frame with explicit first/last windows
    n_pulse = 0;
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, frm[k], 1'b0);
      if (k == 12) check("first", dut_win(), {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
      if (k == 19) begin
        check("last", dut_win(), {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});
        check("last_fd", {71'd0, frame_done}, 72'd1);
        check("ctr", {68'd0, dut.r_row, dut.r_col}, 72'd0);
      end
    end
    check("pulses_cont", n_pulse, 6);

    // back-to-back frame with alternating gaps, then one with random gaps
    n_pulse = 0;
    send_frame(0, W * H - 1, 1);
    check("pulses_alt", n_pulse, 6);
    n_pulse = 0;
    send_frame(0, W * H - 1, 2);
    check("pulses_rand", n_pulse, 6);

    // signed extremes on the corners of the final window
    frm[7] = 8'h80; frm[9] = 8'h7F; frm[17] = 8'hFF; frm[19] = 8'h80;
    n_pulse = 0;
    send_frame(0, W * H - 1, 0);
    check("signed", dut_win(), {8'h80, 8'h08, 8'h7F, 8'h0C, 8'h0D, 8'h0E, 8'hFF, 8'h12, 8'h80});
    check("pulses_signed", n_pulse, 6);
    for (int k = 0; k < W * H; k++) frm[k] = 8'(k);

    // reset mid-frame after pixel 13, then a fresh frame
    send_frame(0, 13, 0);
    do_reset();
    for (int k = 0; k < W * H; k++) frm[k] = 8'(8'h40 + k);
    n_pulse = 0;
    send_frame(0, W * H - 1, 0);
    check("pulses_rst", n_pulse, 6);

    // frame_sync together with a pixel mid-frame
    send_frame(0, 7, 0);
    n_pulse = 0;
    step(1'b1, 8'd100, 1'b1);
    for (int k = 0; k < W * H; k++) frm[k] = 8'(100 + k);
    send_frame(1, W * H - 1, 0);
    check("pulses_sync", n_pulse, 6);
    check("sync_last", dut_win(), {8'd107, 8'd108, 8'd109, 8'd112, 8'd113, 8'd114, 8'd117, 8'd118, 8'd119});

    repeat (3) step(1'b0, 8'h00, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
